apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 113 +++++++++++
 tb/tb_apb_master.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB master: turns one command at a time into an APB SETUP/ACCESS transfer and
// returns a single-cycle response, aborting with a timeout if PREADY never comes.
module apb_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;

   localparam int CW = $clog2(TIMEOUT + 1);
   // The wait count that, incremented once more, would hit TIMEOUT.
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         cmd_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         PSTRB       <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  r_state   <= S_SETUP;
                  r_cnt     <= '0;
                  cmd_ready <= 1'b0;
                  PSEL      <= 1'b1;
                  PENABLE   <= 1'b0;
                  PWRITE    <= cmd_write;
                  PADDR     <= cmd_addr;
                  PWDATA    <= cmd_write ? cmd_wdata : '0;
                  PSTRB     <= cmd_write ? cmd_strb  : '0;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            S_SETUP: begin
               r_state <= S_ACCESS;
               PENABLE <= 1'b1;
            end
            S_ACCESS: begin
               if (PREADY) begin
                  r_state     <= S_IDLE;
                  cmd_ready   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= PSLVERR;
                  rsp_timeout <= 1'b0;
                  rsp_rdata   <= PWRITE ? '0 : PRDATA;
               end else if (r_cnt == LAST_WAIT) begin
                  r_state     <= S_IDLE;
                  r_cnt       <= r_cnt + 1'b1;
                  cmd_ready   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_rdata   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               cmd_ready <= 1'b1;
               PSEL      <= 1'b0;
               PENABLE   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: the slave side is driven by hand cycle by cycle.
module tb_apb_master;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic [3:0]  PSTRB;
   logic        PREADY, PSLVERR;

   int total = 0;
   int bad   = 0;

   apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Present a command for one edge; returns in the SETUP cycle.
   task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   // From SETUP, walk ACCESS cycles; raise PREADY in ACCESS cycle ready_at (0 = never).
   // Returns in the cycle after ACCESS ends, with n = number of ACCESS cycles seen.
   task automatic run_access(input int ready_at, input logic err, input logic [31:0] rd,
                             input logic [7:0] a, output int n);
      n = 0;
      PREADY = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (!(PSEL && PENABLE)) break;
         n++;
         chk("acc_paddr", PADDR, a);
         if (n == ready_at) begin
            PREADY = 1'b1; PSLVERR = err; PRDATA = rd;
         end else begin
            PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hBAD0_0000 | n;
         end
      end
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
   endtask

   task automatic chk_rsp(input string tag, input logic [31:0] rd, input logic e,
                          input logic to);
      chk({tag, "_vld"}, rsp_valid, 1'b1);
      chk({tag, "_rdata"}, rsp_rdata, rd);
      chk({tag, "_err"}, rsp_err, e);
      chk({tag, "_to"}, rsp_timeout, to);
      chk({tag, "_psel"}, PSEL, 1'b0);
      chk({tag, "_rdy"}, cmd_ready, 1'b1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_bus"}, {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB}, 64'h0);
      chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 64'h0);
      chk({tag, "_rdy"}, cmd_ready, 1'b0);
   endtask

   initial begin
      int n;
      PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_strb = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      #2 chk_all_zero("reset");
      #20 PRESETn = 1'b1;
      chk("rst_rel_rdy", cmd_ready, 1'b0);
      tick();
      chk("rst_rdy_rise", cmd_ready, 1'b1);

      // Write, zero wait states.
      issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
      chk("wr_setup", {PSEL, PENABLE, PWRITE, cmd_ready}, 4'b1010);
      chk("wr_paddr", PADDR, 8'h10);
      chk("wr_pwdata", PWDATA, 32'hDEADBEEF);
      chk("wr_pstrb", PSTRB, 4'hF);
      run_access(1, 1'b0, 32'h0, 8'h10, n);
      chk("wr_nacc", n, 1);
      chk_rsp("wr", 32'h0, 1'b0, 1'b0);
      tick();
      chk("wr_pulse", rsp_valid, 1'b0);
      chk("wr_hold_err", rsp_err, 1'b0);

      // Read with 4 wait states.
      issue(1'b0, 8'h10, 32'hFFFFFFFF, 4'hF);
      chk("rd_setup", {PSEL, PENABLE, PWRITE}, 3'b100);
      chk("rd_pwdata0", {PWDATA, PSTRB}, 36'h0);
      run_access(5, 1'b0, 32'hDEADBEEF, 8'h10, n);
      chk("rd_nacc", n, 5);
      chk_rsp("rd", 32'hDEADBEEF, 1'b0, 1'b0);
      tick();
      chk("rd_hold_rdata", rsp_rdata, 32'hDEADBEEF);

      // Write hitting a slave error.
      issue(1'b1, 8'hC0, 32'h0000_00A5, 4'h1);
      run_access(1, 1'b1, 32'h5555_5555, 8'hC0, n);
      chk("err_nacc", n, 1);
      chk_rsp("err", 32'h0, 1'b1, 1'b0);
      tick();

      // Timeout: PREADY never rises.
      issue(1'b0, 8'h44, 32'h0, 4'h0);
      run_access(0, 1'b0, 32'h0, 8'h44, n);
      chk("to_nacc", n, 16);
      chk_rsp("to", 32'h0, 1'b1, 1'b1);
      tick();

      // PREADY on the 16th ACCESS edge completes normally.
      issue(1'b0, 8'h48, 32'h0, 4'h0);
      run_access(16, 1'b0, 32'hCAFE_F00D, 8'h48, n);
      chk("edge_nacc", n, 16);
      chk_rsp("edge", 32'hCAFE_F00D, 1'b0, 1'b0);
      tick();

      // Back-to-back with cmd_valid held: next SETUP right after the response cycle.
      PREADY = 1'b1;
      cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 32'h1111_2222; cmd_strb = 4'h3;
      cmd_valid = 1'b1;
      tick();
      chk("b2b_setup1", {PSEL, PENABLE, PADDR}, {2'b10, 8'h20});
      tick();
      chk("b2b_acc1", {PSEL, PENABLE}, 2'b11);
      tick();
      chk("b2b_rsp1", {rsp_valid, cmd_ready}, 2'b11);
      cmd_addr = 8'h24;
      tick();
      chk("b2b_setup2", {PSEL, PENABLE, PADDR, rsp_valid}, {2'b10, 8'h24, 1'b0});
      cmd_valid = 1'b0;
      tick();
      chk("b2b_acc2", {PSEL, PENABLE}, 2'b11);
      tick();
      chk("b2b_rsp2", {rsp_valid, PSEL}, 2'b10);
      PREADY = 1'b0;
      tick();

      // cmd_valid pulse during ACCESS must be ignored.
      issue(1'b0, 8'h30, 32'h0, 4'h0);
      tick();
      cmd_addr = 8'h99; cmd_write = 1'b1; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("ign_paddr", {PSEL, PENABLE, PWRITE, PADDR}, {3'b110, 8'h30});
      PREADY = 1'b1; PRDATA = 32'h1234_5678;
      tick();
      PREADY = 1'b0; PRDATA = 32'h0;
      chk_rsp("ign", 32'h1234_5678, 1'b0, 1'b0);
      tick();
      chk("ign_no_new", {PSEL, rsp_valid}, 2'b00);

      // Reset in the middle of ACCESS abandons the transfer.
      issue(1'b1, 8'hC4, 32'h7777_8888, 4'hF);
      tick();
      chk("rst_mid_acc", {PSEL, PENABLE}, 2'b11);
      #2 PRESETn = 1'b0;
      #1 chk_all_zero("rst_mid");
      PREADY = 1'b1;
      tick();
      chk("rst_mid_norsp", rsp_valid, 1'b0);
      #3 PRESETn = 1'b1;
      PREADY = 1'b0;
      tick();
      chk("rst_mid_rdy", {cmd_ready, rsp_valid, PSEL}, 3'b100);
      tick();
      chk("rst_mid_idle", {rsp_valid, PSEL}, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
